// File: rtl/thread_fetch_unit_pkg.sv
// Shared fetch-pipeline definitions.
// Holds the PC stride, the default address and thread-index widths, and the
// thread-index type. The fetch unit and the fetch/decode registers use them
// so all pipeline stages agree on these widths.
package thread_fetch_unit_pkg;

    localparam int unsigned PC_STRIDE             = 4;
    localparam int unsigned DEF_ADDR_WIDTH        = 32;
    localparam int unsigned DEF_THREAD_INDEX_BITS = 3;

    typedef logic [DEF_THREAD_INDEX_BITS-1:0] thread_idx_t;

endpackage

// File: rtl/thread_fetch_unit_arbiter.sv
// rr_thread_arbiter: combinational round-robin thread picker.
// Ports:
//   request     in  NUM_THREADS        eligible-thread mask
//   last_grant  in  THREAD_INDEX_BITS  thread granted most recently
//   grant       out THREAD_INDEX_BITS  first requesting thread after last_grant
//   grant_valid out 1                  at least one thread is requesting
module rr_thread_arbiter
    import thread_fetch_unit_pkg::*;
#(
    parameter int THREAD_INDEX_BITS = DEF_THREAD_INDEX_BITS
) (
    input  logic [(2**THREAD_INDEX_BITS)-1:0] request,
    input  logic [THREAD_INDEX_BITS-1:0]      last_grant,
    output logic [THREAD_INDEX_BITS-1:0]      grant,
    output logic                              grant_valid
);

    localparam int NUM_THREADS = 2**THREAD_INDEX_BITS;

    // Scan offsets from farthest to nearest so the nearest requester after
    // last_grant is the one left standing. The index add wraps naturally
    // because NUM_THREADS is a power of two; offset NUM_THREADS lands back on
    // last_grant itself, which therefore has the lowest priority.
    always_comb begin
        logic [THREAD_INDEX_BITS-1:0] w_cand;
        w_cand      = '0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int off = NUM_THREADS; off >= 1; off--) begin
            w_cand = last_grant + THREAD_INDEX_BITS'(off);
            if (request[w_cand]) begin
                grant       = w_cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_fetch_unit.sv
// thread_fetch_unit: per-thread PC store and round-robin fetch issue.
// Each unstalled cycle, one enabled thread is issued. Its PC goes out
// registered, and then the PC steps by PC_STRIDE. A redirect overwrites one
// thread's PC and takes priority over that step.
// Ports:
//   clk               in  1                  clock
//   reset             in  1                  synchronous, active-high
//   stall             in  1                  freeze issue and PC advance
//   thread_enable     in  NUM_THREADS        per-thread run mask
//   redirect_valid    in  1                  branch/jump writeback strobe
//   redirect_thread   in  THREAD_INDEX_BITS  thread being redirected
//   redirect_pc       in  ADDR_WIDTH         new PC for redirect_thread
//   out_fetch_valid   out 1                  out_pc/out_thread_index are live
//   out_pc            out ADDR_WIDTH         instruction-memory address
//   out_thread_index  out THREAD_INDEX_BITS  owner of out_pc
module thread_fetch_unit
    import thread_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int                    THREAD_INDEX_BITS = DEF_THREAD_INDEX_BITS,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic [(2**THREAD_INDEX_BITS)-1:0] thread_enable,
    input  logic                              redirect_valid,
    input  logic [THREAD_INDEX_BITS-1:0]      redirect_thread,
    input  logic [ADDR_WIDTH-1:0]             redirect_pc,
    output logic                              out_fetch_valid,
    output logic [ADDR_WIDTH-1:0]             out_pc,
    output logic [THREAD_INDEX_BITS-1:0]      out_thread_index
);

    localparam int NUM_THREADS = 2**THREAD_INDEX_BITS;

    logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] r_pc;
    logic [THREAD_INDEX_BITS-1:0]           r_last_issued;
    logic                                   r_out_valid;
    logic [ADDR_WIDTH-1:0]                  r_out_pc;
    logic [THREAD_INDEX_BITS-1:0]           r_out_thread;

    logic [THREAD_INDEX_BITS-1:0]           w_grant;
    logic                                   w_grant_valid;

    rr_thread_arbiter #(
        .THREAD_INDEX_BITS (THREAD_INDEX_BITS)
    ) u_arbiter (
        .request     (thread_enable),
        .last_grant  (r_last_issued),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= RESET_PC;
            end
            // Start "after" the top thread so the first issue is thread 0.
            r_last_issued <= THREAD_INDEX_BITS'(NUM_THREADS - 1);
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_thread  <= '0;
        end else begin
            if (!stall) begin
                if (w_grant_valid) begin
                    r_out_valid      <= 1'b1;
                    r_out_pc         <= r_pc[w_grant];
                    r_out_thread     <= w_grant;
                    r_pc[w_grant]    <= r_pc[w_grant] + ADDR_WIDTH'(PC_STRIDE);
                    r_last_issued    <= w_grant;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            // Placed after the increment so a redirect to the thread just
            // issued wins; it also applies while stalled.
            if (redirect_valid) begin
                r_pc[redirect_thread] <= redirect_pc;
            end
        end
    end

    assign out_fetch_valid  = r_out_valid;
    assign out_pc           = r_out_pc;
    assign out_thread_index = r_out_thread;

endmodule

// File: tb/tb_thread_fetch_unit.sv
module tb_thread_fetch_unit;

    localparam int NT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [7:0]  thread_enable;
    logic        redirect_valid;
    logic [2:0]  redirect_thread;
    logic [31:0] redirect_pc;
    logic        out_fetch_valid;
    logic [31:0] out_pc;
    logic [2:0]  out_thread_index;

    int n_checks = 0;
    int n_errors = 0;

    thread_fetch_unit #(
        .ADDR_WIDTH        (32),
        .THREAD_INDEX_BITS (3),
        .RESET_PC          (32'h0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .thread_enable    (thread_enable),
        .redirect_valid   (redirect_valid),
        .redirect_thread  (redirect_thread),
        .redirect_pc      (redirect_pc),
        .out_fetch_valid  (out_fetch_valid),
        .out_pc           (out_pc),
        .out_thread_index (out_thread_index)
    );

    always #5 clk = ~clk;

    // Reference model: the scheduling rule applied directly to plain arrays.
    logic [31:0] m_pc [NT];
    int          m_last;
    bit          m_valid;
    logic [31:0] m_opc;
    int          m_oidx;
    bit          m_ready = 1'b0;

    always @(posedge clk) begin
        int sel;
        if (reset) begin
            for (int t = 0; t < NT; t++) m_pc[t] = 32'h0;
            m_last  = NT - 1;
            m_valid = 1'b0;
            m_opc   = 32'h0;
            m_oidx  = 0;
        end else begin
            sel = -1;
            for (int k = 1; k <= NT; k++) begin
                if (sel < 0 && thread_enable[(m_last + k) % NT]) sel = (m_last + k) % NT;
            end
            if (!stall) begin
                if (sel >= 0) begin
                    m_valid  = 1'b1;
                    m_opc    = m_pc[sel];
                    m_oidx   = sel;
                    m_pc[sel] = m_pc[sel] + 32'd4;
                    m_last   = sel;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (redirect_valid) m_pc[redirect_thread] = redirect_pc;
        end
        m_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            n_checks++;
            if (out_fetch_valid !== m_valid) begin
                n_errors++;
                $display("FAIL model_valid t=%0t got %0b want %0b", $time, out_fetch_valid, m_valid);
            end
            n_checks++;
            if (out_pc !== m_opc) begin
                n_errors++;
                $display("FAIL model_pc t=%0t got %h want %h", $time, out_pc, m_opc);
            end
            n_checks++;
            if (out_thread_index !== m_oidx[2:0]) begin
                n_errors++;
                $display("FAIL model_thread t=%0t got %0d want %0d", $time, out_thread_index, m_oidx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input bit v, input logic [31:0] pc, input int idx);
        n_checks++;
        if (out_fetch_valid !== v || out_pc !== pc || out_thread_index !== idx[2:0]) begin
            n_errors++;
            $display("FAIL %s got v=%0b pc=%h th=%0d want v=%0b pc=%h th=%0d",
                     name, out_fetch_valid, out_pc, out_thread_index, v, pc, idx);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        expect_out("reset_state", 1'b0, 32'h0, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        thread_enable   = 8'hFF;
        redirect_valid  = 1'b0;
        redirect_thread = 3'd0;
        redirect_pc     = 32'h0;

        // Full rotation from reset, then wrap back to threads 0 and 1.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out("rr_first_pass", 1'b1, 32'h0, i);
        end
        tick(); expect_out("rr_wrap_t0", 1'b1, 32'h4, 0);
        tick(); expect_out("rr_wrap_t1", 1'b1, 32'h4, 1);

        // Sparse mask 0x05.
        do_reset();
        thread_enable = 8'h05;
        tick(); expect_out("sparse_0", 1'b1, 32'h0, 0);
        tick(); expect_out("sparse_1", 1'b1, 32'h0, 2);
        tick(); expect_out("sparse_2", 1'b1, 32'h4, 0);
        tick(); expect_out("sparse_3", 1'b1, 32'h4, 2);

        // Stall after thread 3 issues; redirect during stall still lands.
        do_reset();
        thread_enable = 8'hFF;
        for (int i = 0; i < 4; i++) tick();
        expect_out("pre_stall_t3", 1'b1, 32'h0, 3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                redirect_valid  = 1'b1;
                redirect_thread = 3'd5;
                redirect_pc     = 32'h40;
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
            expect_out("stall_hold", 1'b1, 32'h0, 3);
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        tick(); expect_out("post_stall_t4", 1'b1, 32'h0, 4);
        tick(); expect_out("stalled_redirect_t5", 1'b1, 32'h40, 5);

        // Redirect thread 2 in the same cycle it issues 0x8.
        do_reset();
        thread_enable = 8'hFF;
        for (int i = 0; i < 18; i++) tick();
        expect_out("pre_redirect_t1", 1'b1, 32'h8, 1);
        redirect_valid  = 1'b1;
        redirect_thread = 3'd2;
        redirect_pc     = 32'h100;
        tick(); expect_out("redirect_issue_old", 1'b1, 32'h8, 2);
        redirect_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        tick(); expect_out("redirect_issue_new", 1'b1, 32'h100, 2);

        // All threads disabled, then only thread 4 with its preserved PC.
        thread_enable = 8'h00;
        tick(); expect_out("idle_0", 1'b0, 32'h100, 2);
        tick(); expect_out("idle_1", 1'b0, 32'h100, 2);
        thread_enable = 8'h10;
        tick(); expect_out("reenable_t4", 1'b1, 32'hC, 4);
        tick(); expect_out("single_t4", 1'b1, 32'h10, 4);

        // PC wrap at the top of the address space.
        do_reset();
        thread_enable   = 8'h00;
        redirect_valid  = 1'b1;
        redirect_thread = 3'd1;
        redirect_pc     = 32'hFFFF_FFFC;
        tick(); expect_out("wrap_setup", 1'b0, 32'h0, 0);
        redirect_valid = 1'b0;
        thread_enable  = 8'h02;
        tick(); expect_out("wrap_top", 1'b1, 32'hFFFF_FFFC, 1);
        tick(); expect_out("wrap_zero", 1'b1, 32'h0, 1);

        // Reset mid-stream overrides stall and redirect.
        reset           = 1'b1;
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_thread = 3'd3;
        redirect_pc     = 32'h500;
        tick(); expect_out("mid_reset", 1'b0, 32'h0, 0);
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        thread_enable  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out("after_reset_pcs", 1'b1, 32'h0, i);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/thread_fetch_unit.md
THREAD_FETCH_UNIT -- requirements
Module: thread_fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, instruction address width.
REQ-002 Parameter THREAD_INDEX_BITS, default 3, thread index width; NUM_THREADS = 2**THREAD_INDEX_BITS.
REQ-003 Parameter RESET_PC, default 0, PC value every thread loads at reset.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  downstream hold; freezes issue and PC advance.
REQ-007 thread_enable  in  NUM_THREADS  per-thread run mask; bit t=1 makes thread t eligible.
REQ-008 redirect_valid  in  1  branch/jump writeback strobe.
REQ-009 redirect_thread  in  THREAD_INDEX_BITS  thread being redirected.
REQ-010 redirect_pc  in  ADDR_WIDTH  new PC for redirect_thread.
REQ-011 out_fetch_valid  out  1  out_pc/out_thread_index hold a real fetch this cycle.
REQ-012 out_pc  out  ADDR_WIDTH  instruction-memory address.
REQ-013 out_thread_index  out  THREAD_INDEX_BITS  thread owning out_pc; feeds fetch/decode register in_thread_index.

Function
REQ-014 Unit SHALL hold one PC register per thread (NUM_THREADS x ADDR_WIDTH).
REQ-015 Scheduler SHALL pick, round-robin, the first enabled thread strictly after last_issued, searching upward and wrapping NUM_THREADS-1 -> 0.
REQ-016 Cycle with stall=0 and a thread selected: registered outputs SHALL update to out_fetch_valid=1, out_pc=pc[sel], out_thread_index=sel; pc[sel] <= pc[sel]+4; last_issued <= sel.
REQ-017 Latency SHALL be exactly one cycle from selection to registered outputs; outputs SHALL be driven only from flops.
REQ-018 PC increment SHALL wrap modulo 2**ADDR_WIDTH (0xFFFFFFFC -> 0x00000000), no overflow flag.
REQ-019 stall=1: out_fetch_valid, out_pc, out_thread_index, last_issued and all PC increments SHALL hold.
REQ-020 redirect_valid=1 SHALL load pc[redirect_thread] <= redirect_pc on that edge regardless of stall.
REQ-021 Redirect and issue on the same thread in the same cycle: redirect SHALL win (pc = redirect_pc, not +4); the issued out_pc is the pre-redirect value.
REQ-022 thread_enable all zero with stall=0: out_fetch_valid SHALL go 0, out_pc/out_thread_index hold, last_issued holds.
REQ-023 Single enabled thread SHALL issue every unstalled cycle.
REQ-024 thread_enable changes SHALL take effect on the next selection; a disabled thread's PC SHALL be preserved.

Reset
REQ-025 reset=1 SHALL set every pc[t]=RESET_PC, out_fetch_valid=0, out_pc=0, out_thread_index=0, last_issued=NUM_THREADS-1 (so first issue is thread 0).
REQ-026 reset SHALL override stall and redirect; reset mid-operation discards all in-flight state, no partial issue.
REQ-027 First possible out_fetch_valid=1 SHALL be the first edge after reset deasserts.

Structure
REQ-028 Shared pipeline package SHALL hold PC_STRIDE (4), ADDR_WIDTH and THREAD_INDEX_BITS defaults, and the thread-index typedef, reused by fetch/decode registers.
REQ-029 Round-robin selection SHALL be a sub-module rr_thread_arbiter (inputs request mask, last grant; outputs grant index, grant_valid), purely combinational.
REQ-030 PC storage, redirect priority and output registers SHALL reside in thread_fetch_unit.

Verification
REQ-031 Reset, enable=0xFF, no stall: 8 cycles -> threads 0..7 at pc 0x0, then thread 0 at 0x4, thread 1 at 0x4.
REQ-032 enable=0x05: issue order 0,2,0,2 with pcs 0x0,0x0,0x4,0x4.
REQ-033 Stall 3 cycles after thread 3 issues -> outputs frozen at thread 3; thread 4 issues next with unchanged PC.
REQ-034 Redirect thread 2 to 0x100 in the cycle thread 2 issues 0x8 -> out_pc=0x8 now; next thread-2 issue out_pc=0x100.
REQ-035 enable=0x00 for 2 cycles -> out_fetch_valid=0; re-enable 0x10 -> thread 4 issues with its preserved PC.
REQ-036 pc[1]=0xFFFFFFFC issued -> next thread-1 issue out_pc=0x0; reset asserted mid-stream -> next cycle valid=0, all PCs RESET_PC.
